pdm_tx: RTL
===========

# pdm_tx

Transmit-side density modulator for the ultrasound array, running in the 60 MHz `pwm_clk` domain. It converts an 8-bit level into a 1-bit stream whose high count over each `WINDOW`-cycle frame equals that level exactly, using a first-order error accumulator. It is the encoder paired with the window-based high-count sampler, and it drives the differential output pin. Optional LFSR dithering shifts the pulse phase within each frame without changing the per-frame count.

## Interface
- `WINDOW`, default 128: frame length in cycles; must be a power of two, at most 256.
- `LEVEL_W`, default 8: width of `level_in`; must hold the value `WINDOW`.
- `pwm_clk`  in  1  sole clock, 60 MHz.
- `rst`  in  1  reset; synchronous, active-high.
- `level_in`  in  LEVEL_W  requested high count for one frame.
- `level_valid`  in  1  `level_in` is offered.
- `level_ready`  out  1  holding register is empty; the transfer happens when `level_valid && level_ready`.
- `dither_en`  in  1  seed the accumulator from `rand_in` at each frame start.
- `rand_in`  in  log2(WINDOW)  free-running LFSR bits, e.g. `rand_out[6:0]`.
- `bit_out`  out  1  modulated stream; registered.
- `window_start`  out  1  one-cycle pulse, aligned with phase 0 of `bit_out`.
- `underrun`  out  1  sticky; a frame started with no new level pending.

## Operation
- **State:** `phase` counts 0..WINDOW-1 and wraps. Other registers:
  - `level_cur`: clamped level for the current frame.
  - `hold`/`pending`: single-entry holding register.
  - `acc`: accumulator, width log2(WINDOW)+1 bits.
  - `loaded`: set once the first level has been consumed.
- **Accept:** `level_ready = !pending`. On a transfer, `hold <= min(level_in, WINDOW)` and `pending <= 1`. Values above `WINDOW` clamp to `WINDOW`.
- **Frame start (phase 0):**
  - If `pending`: `level_cur <= hold`, `pending <= 0`, `loaded <= 1`.
  - Otherwise: `level_cur` is kept, and `underrun <= 1` if `loaded`.
  - The seed is `rand_in` when `dither_en`, else 0.
- **No bypass:** a transfer completing in the phase-0 cycle lands in `hold` and is used in the next frame. The level used at phase 0 is the value of `hold` before that edge.
- **Per-cycle update (using the level effective this frame):**
  - `s = (phase==0 ? seed : acc) + level`.
  - If `s >= WINDOW`: bit = 1, `acc <= s - WINDOW`. Otherwise bit = 0, `acc <= s`.
- **Per-frame count:** the accumulator is reseeded every frame, so each frame carries exactly `level` ones for any seed in [0, WINDOW). Dither moves only the positions of the ones.
- **Level extremes:** level 0 gives all zeros; level `WINDOW` gives all ones.
- **`underrun`:** cleared only by `rst`.

## Timing
- **Reset values:** while `rst` is high, all of the following hold: `bit_out=0`, `window_start=0`, `level_ready=1`, `underrun=0`, `phase=0`, `acc=0`, `level_cur=0`, `pending=0`, `loaded=0`.
- **First frame:** phase 0 is the first cycle after `rst` falls. `bit_out` and `window_start` for phase p appear one cycle after phase p is computed, so `window_start` marks phase 0 on `bit_out`.
- **Level latency:** a level accepted during frame k (phase 0 excluded) is emitted in frame k+1. A level accepted at phase 0 of frame k is emitted in frame k+2.
- **Ready:** `level_ready` falls the cycle after a transfer. It rises again the cycle after the next phase 0.
- **Reset mid-frame:** the partial frame is abandoned and all state returns to the reset values. No partial count is guaranteed for the abandoned frame.
- **Throughput:** one level per frame at most; `level_valid` held high produces no extra transfers while `pending` is set.

## Test plan
- Level 0, then 128 (no dither) -> frames with 0 and 128 ones, respectively; `window_start` every 128 cycles.
- Level 64, no dither -> `bit_out` pattern 0,1,0,1,... from phase 0; 64 ones per frame.
- Level 1, no dither -> the single one at phase 127. Then dither with `rand_in`=100 -> the single one at phase 27; count still 1.
- Level 200 -> clamped; 128 ones per frame. Random levels with random `rand_in` over 1000 frames -> per-frame count equals the level every time, checked by a 128-cycle counting model aligned on `window_start`.
- Handshake:
  - Offer 10 at phase 5, then 20 immediately -> 10 is accepted and `level_ready` goes low.
  - 20 is accepted after the next phase 0; frames emit 10, then 20.
  - The following frame with no new level repeats 20 and sets `underrun`.
- Assert `rst` at phase 60 with level 50 -> outputs at reset values. After release, `bit_out` stays 0 and `underrun` stays 0 until a new level is accepted.

Source files
------------

// File: rtl/pdm_tx_if.sv
// Level handshake between the level producer and the density modulator.
interface pdm_tx_if #(
  parameter int LEVEL_W = 8
);
  logic [LEVEL_W-1:0] level_in;
  logic               level_valid;
  logic               level_ready;

  modport master (output level_in, output level_valid, input  level_ready);
  modport slave  (input  level_in, input  level_valid, output level_ready);
endinterface

// File: rtl/pdm_tx.sv
// First-order density modulator: each WINDOW-cycle frame carries exactly `level` ones,
// with optional seed dither that moves pulse positions without changing the count.
module pdm_tx #(
  parameter int WINDOW  = 128,
  parameter int LEVEL_W = 8,
  localparam int PW     = $clog2(WINDOW)
) (
  input  logic          pwm_clk,
  input  logic          rst,
  pdm_tx_if.slave       lvl,
  input  logic          dither_en,
  input  logic [PW-1:0] rand_in,
  output logic          bit_out,
  output logic          window_start,
  output logic          underrun
);

  logic [PW-1:0] phase;
  logic [PW:0]   acc, level_cur, hold;
  logic          pending, loaded;

  logic          ph0, xfer, bit_nxt;
  logic [PW:0]   lvl_clamp, lvl_eff, seed, base, acc_nxt;
  logic [PW+1:0] sum, sum_sub;

  assign ph0             = (phase == '0);
  assign lvl.level_ready = !pending;
  assign xfer            = lvl.level_valid && !pending;

  always_comb begin
    lvl_clamp = '0;
    if ({1'b0, lvl.level_in} > (LEVEL_W+1)'(WINDOW))
      lvl_clamp = (PW+1)'(WINDOW);
    else
      lvl_clamp = lvl.level_in[PW:0];
  end

  // The frame's level is taken from hold as it stood before the phase-0 edge,
  // so a transfer in that same cycle waits for the following frame.
  always_comb begin
    lvl_eff = level_cur;
    if (ph0 && pending) lvl_eff = hold;
    seed    = dither_en ? {1'b0, rand_in} : '0;
    base    = ph0 ? seed : acc;
    sum     = {1'b0, base} + {1'b0, lvl_eff};
    sum_sub = sum - (PW+2)'(WINDOW);
    bit_nxt = (sum >= (PW+2)'(WINDOW));
    acc_nxt = bit_nxt ? sum_sub[PW:0] : sum[PW:0];
  end

  always_ff @(posedge pwm_clk) begin
    if (rst) begin
      phase        <= '0;
      acc          <= '0;
      level_cur    <= '0;
      hold         <= '0;
      pending      <= 1'b0;
      loaded       <= 1'b0;
      underrun     <= 1'b0;
      bit_out      <= 1'b0;
      window_start <= 1'b0;
    end else begin
      phase        <= phase + 1'b1;
      acc          <= acc_nxt;
      level_cur    <= lvl_eff;
      bit_out      <= bit_nxt;
      window_start <= ph0;
      if (xfer) hold <= lvl_clamp;
      if (ph0 && pending) begin
        pending <= 1'b0;
        loaded  <= 1'b1;
      end else if (xfer) begin
        pending <= 1'b1;
      end
      if (ph0 && !pending && loaded) underrun <= 1'b1;
    end
  end

endmodule
